quad_debounce: RTL and testbench

- Input conditioning stage that sits directly upstream of the quadrature encoder counter.
- Takes raw, asynchronous, bouncy A/B contacts from a rotary encoder and synchronises them into the clk domain.
- Filters each channel independently: a level is accepted only after it has been stable for STABLE_COUNT cycles.
- Drives clean a/b levels to the encoder, plus per-channel change strobes and a quadrature-violation flag.

---
 rtl/quad_debounce.sv | 88 ++++++++
 tb/tb_quad_debounce.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_debounce.sv
// Input conditioner for a rotary quadrature encoder: synchronises the raw A/B contacts,
// then accepts a new level per channel only after it has held for STABLE_COUNT cycles.
module quad_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 200,
    parameter int CNT_WIDTH    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_edge,
    output logic b_edge,
    output logic quad_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic                   a_s;
    logic                   b_s;
    logic [CNT_WIDTH-1:0]   a_cnt;
    logic [CNT_WIDTH-1:0]   b_cnt;
    logic                   a_accept;
    logic                   b_accept;

    assign a_s = a_sync[SYNC_STAGES-1];
    assign b_s = b_sync[SYNC_STAGES-1];

    // A differing level is accepted on the STABLE_COUNT-th consecutive differing sample.
    assign a_accept = (a_s != a) && (a_cnt == CNT_LAST);
    assign b_accept = (b_s != b) && (b_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_raw};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_raw};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_cnt <= '0;
            a     <= 1'b0;
        end else if (a_s == a) begin
            a_cnt <= '0;
        end else if (a_accept) begin
            a     <= a_s;
            a_cnt <= '0;
        end else begin
            a_cnt <= a_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_cnt <= '0;
            b     <= 1'b0;
        end else if (b_s == b) begin
            b_cnt <= '0;
        end else if (b_accept) begin
            b     <= b_s;
            b_cnt <= '0;
        end else begin
            b_cnt <= b_cnt + 1'b1;
        end
    end

    // Both channels accepting together is an illegal Gray step; it is flagged, not blocked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_edge   <= 1'b0;
            b_edge   <= 1'b0;
            quad_err <= 1'b0;
        end else begin
            a_edge   <= a_accept;
            b_edge   <= b_accept;
            quad_err <= a_accept & b_accept;
        end
    end

endmodule

// File: tb/tb_quad_debounce.sv
// Bench for quad_debounce: a window-based reference model predicts outputs every cycle
// into a queue; a negedge monitor pops and compares against the DUT.
module tb_quad_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int HLEN   = SYNC + STABLE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_raw = 1'b1;
    logic b_raw = 1'b1;
    logic a, b, a_edge, b_edge, quad_err;

    logic [4:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int a_edge_cnt = 0;
    int b_edge_cnt = 0;
    int qerr_cnt = 0;

    quad_debounce #(
        .SYNC_STAGES (SYNC),
        .STABLE_COUNT(STABLE),
        .CNT_WIDTH   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a_raw   (a_raw),
        .b_raw   (b_raw),
        .a       (a),
        .b       (b),
        .a_edge  (a_edge),
        .b_edge  (b_edge),
        .quad_err(quad_err)
    );

    always #5 clk = ~clk;

    // Reference model: history of raw levels sampled at each edge (index 0 = this edge).
    // The filter sees the sample taken SYNC edges earlier; a channel flips when the last
    // STABLE filter samples all disagree with its current level.
    initial begin : model
        logic ha[$];
        logic hb[$];
        logic am, bm, acc_a, acc_b;
        am = 1'b0;
        bm = 1'b0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                ha.delete();
                hb.delete();
                for (int i = 0; i < HLEN; i++) begin
                    ha.push_back(1'b0);
                    hb.push_back(1'b0);
                end
                am = 1'b0;
                bm = 1'b0;
                exp_q.delete();
                exp_q.push_back(5'b0);
            end else begin
                ha.push_front(a_raw);
                hb.push_front(b_raw);
                void'(ha.pop_back());
                void'(hb.pop_back());
                acc_a = 1'b1;
                acc_b = 1'b1;
                for (int i = SYNC; i < HLEN; i++) begin
                    if (ha[i] == am) acc_a = 1'b0;
                    if (hb[i] == bm) acc_b = 1'b0;
                end
                if (acc_a) am = ~am;
                if (acc_b) bm = ~bm;
                exp_q.push_back({am, bm, acc_a, acc_b, acc_a & acc_b});
            end
        end
    end

    initial begin : monitor
        logic [4:0] exp_v;
        logic [4:0] got_v;
        forever begin
            @(negedge clk);
            got_v = {a, b, a_edge, b_edge, quad_err};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t got={a,b,ae,be,qe}=%b", $time, got_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v)  begin
                    errors++;
                    $display("FAIL outputs t=%0t got={a,b,ae,be,qe}=%b expected=%b",
                             $time, got_v, exp_v);
                end
            end
            if (a_edge === 1'b1) a_edge_cnt++;
            if (b_edge === 1'b1) b_edge_cnt++;
            if (quad_err === 1'b1) qerr_cnt++;
        end
    end

    // All drives happen 2 time units after a rising edge.
    task automatic hold(input logic av, input logic bv, input int n);
        a_raw = av;
        b_raw = bv;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        a_edge_cnt = 0;
        b_edge_cnt = 0;
        qerr_cnt   = 0;
    endtask

    task automatic check_counts(input string name, input int ea, input int eb, input int eq);
        checks++;
        if (a_edge_cnt != ea || b_edge_cnt != eb || qerr_cnt != eq) begin
            errors++;
            $display("FAIL %s pulses a_edge=%0d b_edge=%0d quad_err=%0d expected %0d/%0d/%0d",
                     name, a_edge_cnt, b_edge_cnt, qerr_cnt, ea, eb, eq);
        end
    endtask

    initial begin : stimulus
        int na, nb, n;
        logic av, bv;
        // Reset held with both raw inputs high, then release.
        repeat (3) @(posedge clk);
        #2;
        clear_counts();
        reset = 1'b0;
        hold(1'b1, 1'b1, 12);
        check_counts("reset_release", 1, 1, 1);

        hold(1'b0, 1'b0, 12);

        // Clean single-channel step.
        clear_counts();
        hold(1'b1, 1'b0, 12);
        check_counts("clean_step", 1, 0, 0);
        hold(1'b0, 1'b0, 12);

        // Bounce with 3-cycle plateaus, then settle high.
        clear_counts();
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 3);
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 3);
        hold(1'b1, 1'b0, 12);
        check_counts("bounce", 1, 0, 0);
        hold(1'b0, 1'b0, 12);

        // Legal Gray sequence 00 -> 10 -> 11 -> 01 -> 00.
        clear_counts();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 12);
        check_counts("quadrature", 2, 2, 0);

        // Simultaneous change on both channels.
        clear_counts();
        hold(1'b1, 1'b1, 12);
        check_counts("simultaneous", 1, 1, 1);
        hold(1'b0, 1'b0, 12);

        // Reset mid-qualification discards the pending count.
        clear_counts();
        hold(1'b1, 1'b0, 3);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        hold(1'b1, 1'b0, 12);
        check_counts("reset_mid_qualify", 1, 0, 0);

        // Randomized bouncing on independent channels, with occasional resets.
        av = a_raw;
        bv = b_raw;
        na = 0;
        nb = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (na == 0) begin
                av = ~av;
                na = $urandom_range(1, 9);
            end
            if (nb == 0) begin
                bv = ~bv;
                nb = ($urandom_range(0, 7) == 0) ? na : $urandom_range(1, 9);
            end
            na--;
            nb--;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                n = $urandom_range(1, 3);
                hold(av, bv, n);
                reset = 1'b0;
            end
            hold(av, bv, 1);
        end

        hold(a_raw, b_raw, 2);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue_size=%0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
